// File: rtl/pascal_row_checker.sv
// pascal_row_checker: consumes one ROWS-coefficient row per ROWS beats and reports whether it is a Pascal row.
// Optional macro PASCAL_ERR_INDEX_EN adds err_index, the first failing element of the last reported row.
module pascal_row_checker #(
  parameter  int ROWS     = 32,
  localparam int LOG2ROWS = $clog2(ROWS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ROWS-1:0]     in_data,
  output logic                done,
  output logic                row_ok,
  output logic [LOG2ROWS-1:0] nrow_out
`ifdef PASCAL_ERR_INDEX_EN
  ,
  output logic [LOG2ROWS-1:0] err_index
`endif
);

  localparam int PW = ROWS + LOG2ROWS;

  typedef enum logic {ACCEPT = 1'b0, REPORT = 1'b1} state_t;

  state_t              state, state_next;
  logic [LOG2ROWS-1:0] k, n, n_cur, k_m1, factor;
  logic [ROWS-1:0]     prev;
  logic [PW-1:0]       lhs, rhs;
  logic                err, err_next, beat_err, beat, last_beat;

  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (k == LOG2ROWS'(ROWS - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCEPT;
    else     state <= state_next;
  end

  // NOTE: each always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ACCEPT:  if (last_beat) state_next = REPORT;
      REPORT:  state_next = ACCEPT;
      default: state_next = ACCEPT;
    endcase
  end

  always_comb begin
    in_ready = (state == ACCEPT);
    done     = (state == REPORT);
  end

  // Ratio test C(n,k)*k == C(n,k-1)*(n-k+1); at k=1 n is taken straight from the bus.
  always_comb begin
    n_cur  = (k == LOG2ROWS'(1)) ? in_data[LOG2ROWS-1:0] : n;
    k_m1   = k - 1'b1;
    factor = (n_cur >= k_m1) ? n_cur - k_m1 : '0;
    lhs    = PW'(in_data) * PW'(k);
    rhs    = PW'(prev) * PW'(factor);
    if (k == '0)
      beat_err = (in_data != ROWS'(1));
    else
      beat_err = (lhs != rhs) ||
                 ((k == LOG2ROWS'(1)) && (in_data > ROWS'(ROWS - 1)));
    err_next = ((k == '0) ? 1'b0 : err) | beat_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k        <= '0;
      n        <= '0;
      prev     <= '0;
      err      <= 1'b0;
      row_ok   <= 1'b0;
      nrow_out <= '0;
    end else if (beat) begin
      k    <= last_beat ? '0 : k + 1'b1;
      prev <= in_data;
      err  <= err_next;
      if (k == LOG2ROWS'(1)) n <= in_data[LOG2ROWS-1:0];
      // Results are registered on the last beat so they are already valid while done is high.
      if (last_beat) begin
        row_ok   <= !err_next;
        nrow_out <= err_next ? '0 : n;
      end
    end
  end

`ifdef PASCAL_ERR_INDEX_EN
  logic [LOG2ROWS-1:0] fail_idx, fail_idx_next;

  assign fail_idx_next = ((k != '0) && err) ? fail_idx : k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_idx  <= '0;
      err_index <= '0;
    end else if (beat) begin
      fail_idx <= fail_idx_next;
      if (last_beat) err_index <= err_next ? fail_idx_next : '0;
    end
  end
`endif

endmodule

// File: tb/tb_pascal_row_checker.sv
// Self-checking bench for pascal_row_checker: directed rows from the requirement list plus random rows,
// checked against a binomial reference model. Define PASCAL_ERR_INDEX_EN to also check err_index.
module tb_pascal_row_checker;
  localparam int ROWS = 32;
  localparam int LW   = 5;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, done, row_ok;
  logic [ROWS-1:0] in_data;
  logic [LW-1:0]   nrow_out;
`ifdef PASCAL_ERR_INDEX_EN
  logic [LW-1:0]   err_index;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef logic [31:0] row_t [ROWS];
  typedef struct {
    bit         fin, early, rep_done, rep_ready, after_done;
    logic       ok;
    logic [4:0] nrow, eidx;
  } res_t;

  pascal_row_checker #(.ROWS(ROWS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .done     (done),
    .row_ok   (row_ok),
`ifdef PASCAL_ERR_INDEX_EN
    .err_index(err_index),
`endif
    .nrow_out (nrow_out)
  );

  always #5 clk = ~clk;

  // Row n of Pascal's triangle, zero beyond index n.
  function automatic void make_row(input int nn, output row_t d);
    longint unsigned c = 1;
    d[0] = 32'd1;
    for (int i = 1; i < ROWS; i++) begin
      c    = (i > nn) ? 0 : c * longint'(nn - i + 1) / longint'(i);
      d[i] = c[31:0];
    end
  endfunction

  // A row is valid iff it starts with 1, d[1]=n <= ROWS-1 and equals C(n,k) everywhere;
  // the first failing index is the first place it departs from that row.
  function automatic void model(input row_t d, output logic ok, output logic [4:0] nrow,
                                output logic [4:0] eidx);
    row_t ref_row;
    int   fi = -1;
    if (d[0] != 32'd1)           fi = 0;
    else if (d[1] > 32'(ROWS-1)) fi = 1;
    else begin
      make_row(int'(d[1]), ref_row);
      for (int i = 2; i < ROWS; i++)
        if (fi < 0 && d[i] != ref_row[i]) fi = i;
    end
    ok   = (fi < 0);
    nrow = ok ? d[1][4:0] : 5'd0;
    eidx = ok ? 5'd0 : fi[4:0];
  endfunction

  // Streams one row (driven on negedges), then samples the REPORT cycle and the cycle after it.
  task automatic send_row(input row_t d, input int gap_pct, input bit valid_in_report,
                          output res_t r);
    int idx = 0;
    int budget = 0;
    r.early = 0;
    while (idx < ROWS && budget < 2000) begin
      @(negedge clk);
      budget++;
      if (done) r.early = 1;
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end else begin
        in_valid = 1'b1;
        in_data  = d[idx];
        if (in_ready) idx++;
      end
    end
    r.fin = (idx == ROWS);
    @(negedge clk);
    r.rep_done  = done;
    r.rep_ready = in_ready;
    r.ok        = row_ok;
    r.nrow      = nrow_out;
`ifdef PASCAL_ERR_INDEX_EN
    r.eidx = err_index;
`else
    r.eidx = 5'd0;
`endif
    in_valid = valid_in_report;
    in_data  = 32'd7;
    @(negedge clk);
    r.after_done = done;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", done); end
    n_cmp++;
    if (row_ok !== 1'b0) begin n_bad++; $display("FAIL reset_row_ok got %0b want 0", row_ok); end
    n_cmp++;
    if (nrow_out !== 5'd0) begin n_bad++; $display("FAIL reset_nrow got %0d want 0", nrow_out); end
    n_cmp++;
  endtask

  // Valid rows 4, 0 and 31 without gaps, with hand-known answers.
  task automatic test_valid_rows();
    int   ns[3]    = '{4, 0, 31};
    row_t d;
    res_t r;
    for (int t = 0; t < 3; t++) begin
      make_row(ns[t], d);
      send_row(d, 0, 1'b0, r);
      if (!(r.fin && !r.early && r.rep_done && !r.after_done)) begin
        n_bad++;
        $display("FAIL valid_row%0d_timing fin=%0b early=%0b done=%0b after=%0b want 1,0,1,0",
                 ns[t], r.fin, r.early, r.rep_done, r.after_done);
      end
      n_cmp++;
      if (r.ok !== 1'b1) begin n_bad++; $display("FAIL valid_row%0d_ok got %0b want 1", ns[t], r.ok); end
      n_cmp++;
      if (r.nrow !== 5'(ns[t])) begin
        n_bad++; $display("FAIL valid_row%0d_nrow got %0d want %0d", ns[t], r.nrow, ns[t]);
      end
      n_cmp++;
    end
  endtask

  // Row 5 with element 3 = 11, n=40, and row 4 with a stray 1 at index 6.
  task automatic test_errors();
    int   want_idx[3] = '{3, 1, 6};
    row_t d;
    res_t r;
    for (int t = 0; t < 3; t++) begin
      case (t)
        0: begin make_row(5, d); d[3] = 32'd11; end
        1: begin make_row(0, d); d[1] = 32'd40; end
        default: begin make_row(4, d); d[6] = 32'd1; end
      endcase
      send_row(d, 0, 1'b0, r);
      if (!(r.fin && r.rep_done)) begin
        n_bad++; $display("FAIL err%0d_timing fin=%0b done=%0b want 1,1", t, r.fin, r.rep_done);
      end
      n_cmp++;
      if (r.ok !== 1'b0) begin n_bad++; $display("FAIL err%0d_ok got %0b want 0", t, r.ok); end
      n_cmp++;
      if (r.nrow !== 5'd0) begin n_bad++; $display("FAIL err%0d_nrow got %0d want 0", t, r.nrow); end
      n_cmp++;
`ifdef PASCAL_ERR_INDEX_EN
      if (r.eidx !== 5'(want_idx[t])) begin
        n_bad++; $display("FAIL err%0d_index got %0d want %0d", t, r.eidx, want_idx[t]);
      end
      n_cmp++;
`endif
    end
  endtask

  // Row 6 with gaps and in_valid held during REPORT, then row 3 back to back: if the REPORT
  // beat were consumed, row 3 would start with 7 and fail.
  task automatic test_gaps();
    row_t d;
    res_t r;
    make_row(6, d);
    send_row(d, 35, 1'b1, r);
    if (!(r.fin && !r.early && r.rep_done && !r.after_done)) begin
      n_bad++; $display("FAIL gaps_timing fin=%0b early=%0b done=%0b after=%0b want 1,0,1,0",
                        r.fin, r.early, r.rep_done, r.after_done);
    end
    n_cmp++;
    if (r.rep_ready !== 1'b0) begin n_bad++; $display("FAIL gaps_report_ready got %0b want 0", r.rep_ready); end
    n_cmp++;
    if (r.ok !== 1'b1 || r.nrow !== 5'd6) begin
      n_bad++; $display("FAIL gaps_result got ok=%0b n=%0d want ok=1 n=6", r.ok, r.nrow);
    end
    n_cmp++;
    make_row(3, d);
    send_row(d, 0, 1'b0, r);
    if (r.ok !== 1'b1 || r.nrow !== 5'd3 || !r.rep_done) begin
      n_bad++; $display("FAIL after_report_row got ok=%0b n=%0d done=%0b want 1,3,1", r.ok, r.nrow, r.rep_done);
    end
    n_cmp++;
    repeat (5) @(negedge clk);
    if (row_ok !== 1'b1 || nrow_out !== 5'd3 || done !== 1'b0) begin
      n_bad++; $display("FAIL hold got ok=%0b n=%0d done=%0b want 1,3,0", row_ok, nrow_out, done);
    end
    n_cmp++;
  endtask

  task automatic test_mid_reset();
    row_t d;
    res_t r;
    bit   saw = 0;
    make_row(3, d);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) saw = 1;
      in_valid = 1'b1;
      in_data  = d[i];
    end
    @(negedge clk);
    if (done) saw = 1;
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    if (saw) begin n_bad++; $display("FAIL midrst_no_done got done=1 want 0"); end
    n_cmp++;
    if (in_ready !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL midrst_ctrl got ready=%0b done=%0b want 1,0", in_ready, done);
    end
    n_cmp++;
    if (row_ok !== 1'b0 || nrow_out !== 5'd0) begin
      n_bad++; $display("FAIL midrst_clear got ok=%0b n=%0d want 0,0", row_ok, nrow_out);
    end
    n_cmp++;
    @(negedge clk);
    rst = 1'b0;
    make_row(2, d);
    send_row(d, 0, 1'b0, r);
    if (!(r.fin && !r.early && r.rep_done) || r.ok !== 1'b1 || r.nrow !== 5'd2) begin
      n_bad++; $display("FAIL midrst_row2 got fin=%0b early=%0b done=%0b ok=%0b n=%0d want 1,0,1,1,2",
                        r.fin, r.early, r.rep_done, r.ok, r.nrow);
    end
    n_cmp++;
  endtask

  task automatic test_random();
    row_t       d;
    res_t       r;
    logic       eok;
    logic [4:0] en, ei;
    for (int t = 0; t < 24; t++) begin
      make_row(int'($urandom_range(0, ROWS - 1)), d);
      if ($urandom_range(1)) begin
        int idx = int'($urandom_range(0, ROWS - 1));
        d[idx] = d[idx] ^ (32'd1 << $urandom_range(0, 7));
      end
      model(d, eok, en, ei);
      send_row(d, int'($urandom_range(0, 40)), 1'($urandom_range(1)), r);
      if (!(r.fin && !r.early && r.rep_done && !r.after_done) || r.rep_ready !== 1'b0) begin
        n_bad++; $display("FAIL rand%0d_timing fin=%0b early=%0b done=%0b after=%0b ready=%0b want 1,0,1,0,0",
                          t, r.fin, r.early, r.rep_done, r.after_done, r.rep_ready);
      end
      n_cmp++;
      if (r.ok !== eok || r.nrow !== en) begin
        n_bad++; $display("FAIL rand%0d_result got ok=%0b n=%0d want ok=%0b n=%0d", t, r.ok, r.nrow, eok, en);
      end
      n_cmp++;
`ifdef PASCAL_ERR_INDEX_EN
      if (r.eidx !== ei) begin n_bad++; $display("FAIL rand%0d_index got %0d want %0d", t, r.eidx, ei); end
      n_cmp++;
`endif
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_valid_rows();
    test_errors();
    test_gaps();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
